// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// This block is the hazard and flush controller for the 5-stage MIPS
// pipeline. It sits beside the ID stage and decides, every cycle, whether
// the front end must hold, whether a bubble goes into EX, and which pipeline
// registers are cleared.
//
// It handles four things:
//   * Load-use hazards. The stall lasts LOAD_STALL cycles and is timed by
//     an internal counter and FSM.
//   * Branch-operand hazards. A branch compares its operands in ID, so it
//     stalls for BR_STALL cycles when one of those operands is still being
//     produced by an ALU op in EX.
//   * Control-flow flushes. These come from jumps, taken branches and
//     undefined opcodes.
//   * External interrupts. A request is latched, and it is taken only on a
//     cycle where nothing else is redirecting or holding the pipeline.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          asynchronous, active-high reset
//   id_rs, id_rt   source register indices of the instruction in ID
//   id_use_rs/rt   the ID instruction actually reads rs / rt
//   id_is_branch   ID instruction is beq/bne (operands compared in ID)
//   ex_rd          destination index of the instruction in EX
//   ex_regwrite    EX instruction writes a register
//   ex_memread     EX instruction is a load
//   jump_taken     j/jal/jr decoded in ID
//   branch_taken   branch resolved taken
//   bad_instr      undefined opcode in ID
//   irq            external interrupt request, level sensitive
//   kernel         PC[31]; masks capture of new interrupts
//   stall          hold the PC and IF/ID
//   bubble_ex      load a NOP into ID/EX
//   flush_if_id    clear IF/ID
//   flush_id_ex    clear ID/EX
//   irq_take       one-cycle pulse: redirect the PC to the interrupt vector
//   stall_cnt      remaining stall cycles (debug view of the counter)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int BR_STALL   = 1,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              jump_taken,
    input  logic              branch_taken,
    input  logic              bad_instr,
    input  logic              irq,
    input  logic              kernel,
    output logic              stall,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              irq_take,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // The first stall cycle is spent in RUN, in the cycle where the hazard
    // is detected. The counter therefore only has to cover the remaining
    // N-1 cycles. When N is 1, the FSM never leaves RUN.
    localparam logic [CNT_W-1:0] LOAD_CNT   = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] BR_CNT     = CNT_W'(BR_STALL - 1);
    localparam logic             LOAD_MULTI = (LOAD_STALL > 1);
    localparam logic             BR_MULTI   = (BR_STALL > 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             irq_pend;
    logic             irq_pend_next;

    logic             rs_hit;
    logic             rt_hit;
    logic             match;
    logic             load_haz;
    logic             br_haz;
    logic             ctrl_flush;
    logic             take_now;
    logic             flush_req;

    // Operand match against the EX destination.
    // Register $0 is hard-wired to zero, so a write to it can never create
    // a dependency. That is why a zero ex_rd suppresses the match.
    // A branch that sits behind a load is treated as a load-use hazard, so
    // it gets the longer load timing. For that reason br_haz excludes
    // ex_memread.
    always_comb begin
        rs_hit   = id_use_rs && (id_rs == ex_rd);
        rt_hit   = id_use_rt && (id_rt == ex_rd);
        match    = (ex_rd != '0) && (rs_hit || rt_hit);
        load_haz = ex_memread && match;
        br_haz   = id_is_branch && ex_regwrite && !ex_memread && match;
    end

    // Interrupt acceptance and the combined flush request.
    // A pending interrupt is taken only in a cycle that is otherwise calm:
    // the FSM is in RUN, no hazard is being raised, and ID is not already
    // redirecting the PC. Taking the interrupt is itself a flush, so it
    // cancels any pending stall in the same way a jump would.
    always_comb begin
        ctrl_flush = jump_taken || branch_taken || bad_instr;
        take_now   = irq_pend && (state == RUN) && !load_haz && !br_haz
                     && !ctrl_flush;
        flush_req  = ctrl_flush || take_now;
    end

    // State register, stall counter and interrupt latch.
    // Reset is asynchronous, so a stall that is in progress is abandoned
    // immediately. Any latched interrupt is dropped at the same time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            irq_pend <= irq_pend_next;
        end
    end

    // Next-state logic.
    // A flush always wins. The instructions that were waiting on the stall
    // are being discarded, so the counter is cleared and the FSM returns to
    // RUN.
    // While in STALL, hazards are deliberately ignored. The counter just
    // runs down, and the FSM leaves STALL on the edge where it reads 1, so
    // RUN is entered with the counter already at 0.
    // An interrupt is remembered until it is taken, even if the request
    // line drops. kernel only blocks new captures. When the take and a new
    // capture happen on the same edge, the take clears the latch, so one
    // request produces one vector redirect.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        irq_pend_next = irq_pend;

        if (flush_req) begin
            state_next = RUN;
            cnt_next   = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (load_haz) begin
                        cnt_next   = LOAD_CNT;
                        state_next = LOAD_MULTI ? STALL : RUN;
                    end else if (br_haz) begin
                        cnt_next   = BR_CNT;
                        state_next = BR_MULTI ? STALL : RUN;
                    end
                end
                STALL: begin
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end

        if (take_now) begin
            irq_pend_next = 1'b0;
        end else if (irq && !kernel) begin
            irq_pend_next = 1'b1;
        end
    end

    // Output logic.
    // Stall and bubble are asserted together: the front end holds while
    // EX receives a NOP. Both are asserted in every STALL cycle, and in the
    // RUN cycle where a hazard is first seen.
    // A jump only needs to discard the fetched instruction in IF/ID. A
    // taken branch, a bad opcode or an interrupt must also squash the
    // instruction that is moving from ID into EX.
    always_comb begin
        stall       = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        irq_take    = 1'b0;
        stall_cnt   = cnt;

        if (!flush_req) begin
            if ((state == STALL) || load_haz || br_haz) begin
                stall     = 1'b1;
                bubble_ex = 1'b1;
            end
        end

        flush_if_id = flush_req;
        flush_id_ex = branch_taken || bad_instr || take_now;
        irq_take    = take_now;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// This bench drives two instances of hazard_ctrl from the same inputs.
// They use different stall lengths:
//   * u_a: LOAD_STALL=3, BR_STALL=1
//   * u_b: LOAD_STALL=1, BR_STALL=2
// Both instances are compared on every falling edge against a behavioural
// model. The model tracks only two things per instance: "stall cycles
// still owed" and "interrupt waiting".
// The directed section also pins known sequences with literal expected
// vectors.
//
// The expected vectors are packed as
//   {stall, bubble_ex, flush_if_id, flush_id_ex, irq_take, stall_cnt[2:0]}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       id_is_branch;
        logic [4:0] ex_rd;
        logic       ex_regwrite;
        logic       ex_memread;
        logic       jump_taken;
        logic       branch_taken;
        logic       bad_instr;
        logic       irq;
        logic       kernel;
    } stim_t;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_branch;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       jump_taken;
    logic       branch_taken;
    logic       bad_instr;
    logic       irq;
    logic       kernel;

    logic       stall_a, bubble_a, fif_a, fie_a, take_a;
    logic [2:0] cnt_a;
    logic       stall_b, bubble_b, fif_b, fie_b, take_b;
    logic [2:0] cnt_b;
    logic [7:0] out_a;
    logic [7:0] out_b;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model state, one entry per instance:
    //   owed[k]: stall cycles still owed, which is also the expected counter
    //   pend[k]: an interrupt is waiting to be taken
    int load_len[2] = '{3, 1};
    int br_len[2]   = '{1, 2};
    int owed[2]     = '{0, 0};
    bit pend[2]     = '{0, 0};

    assign out_a = {stall_a, bubble_a, fif_a, fie_a, take_a, cnt_a};
    assign out_b = {stall_b, bubble_b, fif_b, fie_b, take_b, cnt_b};

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .BR_STALL(1), .CNT_W(3)) u_a (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .jump_taken(jump_taken), .branch_taken(branch_taken),
        .bad_instr(bad_instr), .irq(irq), .kernel(kernel),
        .stall(stall_a), .bubble_ex(bubble_a), .flush_if_id(fif_a),
        .flush_id_ex(fie_a), .irq_take(take_a), .stall_cnt(cnt_a)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .BR_STALL(2), .CNT_W(3)) u_b (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .jump_taken(jump_taken), .branch_taken(branch_taken),
        .bad_instr(bad_instr), .irq(irq), .kernel(kernel),
        .stall(stall_b), .bubble_ex(bubble_b), .flush_if_id(fif_b),
        .flush_id_ex(fie_b), .irq_take(take_b), .stall_cnt(cnt_b)
    );

    // 10-time-unit clock. Inputs change 1 unit after the rising edge, and
    // outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Does the ID instruction depend on the EX destination?
    function automatic bit depends();
        return (ex_rd != 5'd0) &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    // Hazard seen this cycle by instance k.
    // Returns the stall length it asks for, or 0 when there is no hazard.
    // Hazards only count while the instance is not already stalling.
    function automatic int hazard_len(int k);
        if (owed[k] != 0 || !depends()) return 0;
        if (ex_memread) return load_len[k];
        if (id_is_branch && ex_regwrite) return br_len[k];
        return 0;
    endfunction

    function automatic bit model_take(int k);
        return pend[k] && owed[k] == 0 && hazard_len(k) == 0 &&
               !jump_taken && !branch_taken && !bad_instr;
    endfunction

    function automatic logic [7:0] model_out(int k);
        bit take;
        bit redirect;
        bit hold;
        take     = model_take(k);
        redirect = jump_taken || branch_taken || bad_instr || take;
        hold     = !redirect && (owed[k] != 0 || hazard_len(k) != 0);
        return {hold, hold, redirect, branch_taken || bad_instr || take, take,
                3'(owed[k])};
    endfunction

    // Advance the model at each clock edge. Reset clears it immediately,
    // exactly as the hardware does.
    // A flush discards whatever stall was owed. An ongoing stall burns one
    // cycle per edge. A new hazard has already spent its first cycle, so
    // N-1 cycles remain owed after the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                owed[k] = 0;
                pend[k] = 1'b0;
            end
        end else begin
            cycle++;
            for (int k = 0; k < 2; k++) begin
                bit take;
                int len;
                take = model_take(k);
                len  = hazard_len(k);
                if (jump_taken || branch_taken || bad_instr || take) owed[k] = 0;
                else if (owed[k] != 0) owed[k] = owed[k] - 1;
                else if (len != 0) owed[k] = len - 1;
                if (take) pend[k] = 1'b0;
                else if (irq && !kernel) pend[k] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        checkOutput($sformatf("model cyc%0d dut_a", cycle), out_a, model_out(0));
        checkOutput($sformatf("model cyc%0d dut_b", cycle), out_b, model_out(1));
    end

    task automatic drive(input stim_t s);
        id_rs        = s.id_rs;
        id_rt        = s.id_rt;
        id_use_rs    = s.id_use_rs;
        id_use_rt    = s.id_use_rt;
        id_is_branch = s.id_is_branch;
        ex_rd        = s.ex_rd;
        ex_regwrite  = s.ex_regwrite;
        ex_memread   = s.ex_memread;
        jump_taken   = s.jump_taken;
        branch_taken = s.branch_taken;
        bad_instr    = s.bad_instr;
        irq          = s.irq;
        kernel       = s.kernel;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
    endtask

    // Apply one cycle of stimulus, then check both instances at the
    // falling edge against hand-worked vectors.
    task automatic stepAndCheck(input stim_t s, input string name,
                                input logic [7:0] exp_a, input logic [7:0] exp_b);
        applyStimulus(s);
        @(negedge clk);
        checkOutput({name, " a"}, out_a, exp_a);
        checkOutput({name, " b"}, out_b, exp_b);
    endtask

    stim_t s_zero;
    stim_t s_load;
    stim_t s_load_irq;
    stim_t s_br;
    stim_t s_tmp;

    initial begin
        s_zero = '0;
        s_load = '0;
        s_load.ex_memread = 1'b1;
        s_load.ex_rd      = 5'd8;
        s_load.id_rs      = 5'd8;
        s_load.id_use_rs  = 1'b1;
        s_load_irq        = s_load;
        s_load_irq.irq    = 1'b1;
        s_br = '0;
        s_br.id_is_branch = 1'b1;
        s_br.ex_regwrite  = 1'b1;
        s_br.ex_rd        = 5'd5;
        s_br.id_rt        = 5'd5;
        s_br.id_use_rt    = 1'b1;

        reset = 1'b1;
        drive(s_zero);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("after reset a", out_a, 8'h00);
        checkOutput("after reset b", out_b, 8'h00);

        // Load-use stall: 3 cycles on u_a (counter 0,2,1), 1 cycle on u_b.
        stepAndCheck(s_load, "load c1", 8'hC0, 8'hC0);
        stepAndCheck(s_zero, "load c2", 8'hC2, 8'h00);
        stepAndCheck(s_zero, "load c3", 8'hC1, 8'h00);
        stepAndCheck(s_zero, "load c4", 8'h00, 8'h00);
        s_tmp = s_load;
        s_tmp.ex_rd = 5'd0;
        s_tmp.id_rs = 5'd0;
        stepAndCheck(s_tmp, "load r0", 8'h00, 8'h00);

        // Branch-operand stall: 1 cycle on u_a, 2 cycles on u_b, no flush.
        stepAndCheck(s_br,   "br c1", 8'hC0, 8'hC0);
        stepAndCheck(s_zero, "br c2", 8'h00, 8'hC1);
        stepAndCheck(s_zero, "br c3", 8'h00, 8'h00);
        s_tmp = s_br;
        s_tmp.id_is_branch = 1'b0;
        stepAndCheck(s_tmp, "nobranch", 8'h00, 8'h00);

        // A taken branch in the second stall cycle overrides the stall.
        // The counter is still visible during that cycle and reads 0
        // afterwards.
        stepAndCheck(s_load, "flush c1", 8'hC0, 8'hC0);
        s_tmp = s_zero;
        s_tmp.branch_taken = 1'b1;
        stepAndCheck(s_tmp,  "flush c2", 8'h32, 8'h30);
        stepAndCheck(s_zero, "flush c3", 8'h00, 8'h00);
        s_tmp = s_zero;
        s_tmp.jump_taken = 1'b1;
        stepAndCheck(s_tmp,  "jump", 8'h20, 8'h20);

        // An interrupt pulse during the stall. u_b is already back in RUN
        // in the next cycle, so it takes the interrupt then. u_a waits
        // until its stall ends.
        stepAndCheck(s_load_irq, "irq c1", 8'hC0, 8'hC0);
        stepAndCheck(s_zero, "irq c2", 8'hC2, 8'h38);
        stepAndCheck(s_zero, "irq c3", 8'hC1, 8'h00);
        stepAndCheck(s_zero, "irq c4", 8'h38, 8'h00);
        stepAndCheck(s_zero, "irq c5", 8'h00, 8'h00);
        s_tmp = s_zero;
        s_tmp.irq    = 1'b1;
        s_tmp.kernel = 1'b1;
        stepAndCheck(s_tmp,  "irq kern c1", 8'h00, 8'h00);
        stepAndCheck(s_zero, "irq kern c2", 8'h00, 8'h00);
        stepAndCheck(s_zero, "irq kern c3", 8'h00, 8'h00);

        // Asynchronous reset with u_a mid-stall (counter 2) and u_b about
        // to take a pending interrupt.
        stepAndCheck(s_load_irq, "rst c1", 8'hC0, 8'hC0);
        applyStimulus(s_zero);
        #1 reset = 1'b1;
        #1;
        checkOutput("async rst a", out_a, 8'h00);
        checkOutput("async rst b", out_b, 8'h00);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post rst a", out_a, 8'h00);
        checkOutput("post rst b", out_b, 8'h00);
        stepAndCheck(s_zero, "post rst c2", 8'h00, 8'h00);

        // Randomized traffic. Register indices are kept small so that
        // matches, including $0, happen often.
        for (int i = 0; i < 3000; i++) begin
            s_tmp.id_rs        = 5'($urandom_range(0, 3));
            s_tmp.id_rt        = 5'($urandom_range(0, 3));
            s_tmp.id_use_rs    = 1'($urandom_range(0, 1));
            s_tmp.id_use_rt    = 1'($urandom_range(0, 1));
            s_tmp.id_is_branch = ($urandom_range(0, 2) == 0);
            s_tmp.ex_rd        = 5'($urandom_range(0, 3));
            s_tmp.ex_regwrite  = 1'($urandom_range(0, 1));
            s_tmp.ex_memread   = ($urandom_range(0, 3) == 0);
            s_tmp.jump_taken   = ($urandom_range(0, 15) == 0);
            s_tmp.branch_taken = ($urandom_range(0, 15) == 0);
            s_tmp.bad_instr    = ($urandom_range(0, 31) == 0);
            s_tmp.irq          = ($urandom_range(0, 9) == 0);
            s_tmp.kernel       = ($urandom_range(0, 3) == 0);
            applyStimulus(s_tmp);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        applyStimulus(s_zero);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
